// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states and the
// imm_type / alu_op codes that the immediate generator and ALU also decode.
package multicycle_ctrl_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_WB,
        ST_BRANCH,
        ST_FAULT
    } state_e;

    typedef enum logic [1:0] {
        IMM_I    = 2'd0,
        IMM_S    = 2'd1,
        IMM_B    = 2'd2,
        IMM_NONE = 2'd3
    } imm_type_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_CMP   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_e;

    function automatic logic is_mem_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle. master = controller, slave = the
// datapath and memory side that supplies decode fields and handshakes.
interface multicycle_ctrl_if;
    import multicycle_ctrl_pkg::*;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       br_taken;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    imm_type_e  imm_type;
    logic       alu_src_b;
    alu_op_e    alu_op;
    logic       reg_we;
    logic       wb_sel;
    logic       fault;

    modport master (
        input  opcode, funct3, br_taken, mem_ready,
        output mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src,
               imm_type, alu_src_b, alu_op, reg_we, wb_sel, fault
    );

    modport slave (
        output opcode, funct3, br_taken, mem_ready,
        input  mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src,
               imm_type, alu_src_b, alu_op, reg_we, wb_sel, fault
    );

endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts cycles a memory request waits for mem_ready; o_timeout fires on the
// wait cycle that brings the count to MEM_TIMEOUT.
module multicycle_ctrl_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_timeout
);

    localparam int               CNT_W     = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!i_rst_n || i_clear) begin
            r_count <= '0;
        end else if (i_count_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    // A mem_ready on this same cycle keeps i_count_en low, so completion wins.
    assign o_timeout = i_count_en && (r_count == LAST_WAIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset control FSM: state register plus Moore output decode
// (FETCH/BRANCH enables also qualified by mem_ready / br_taken).
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);

    state_e    r_state;
    logic      w_in_mem;
    logic      w_timeout;
    logic      w_timer_clear;
    logic      w_timer_en;
    logic      w_unused;

    logic      w_mem_req, w_mem_we, w_addr_sel, w_ir_we, w_pc_we, w_pc_src;
    logic      w_alu_src_b, w_reg_we, w_wb_sel, w_fault;
    imm_type_e w_imm_type;
    alu_op_e   w_alu_op;

    assign w_in_mem      = is_mem_state(r_state);
    assign w_timer_clear = !w_in_mem || bus.mem_ready;
    assign w_timer_en    = w_mem_req && !bus.mem_ready;
    assign w_unused      = ^bus.funct3;

    multicycle_ctrl_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk        (clk),
        .i_rst_n    (rst_n),
        .i_clear    (w_timer_clear),
        .i_count_en (w_timer_en),
        .o_timeout  (w_timeout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (bus.mem_ready)  r_state <= ST_DECODE;
                    else if (w_timeout) r_state <= ST_FAULT;
                end
                ST_DECODE: begin
                    case (bus.opcode)
                        OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE: r_state <= ST_EXEC;
                        OP_BRANCH:                             r_state <= ST_BRANCH;
                        default:                               r_state <= ST_FAULT;
                    endcase
                end
                ST_EXEC: begin
                    case (bus.opcode)
                        OP_LOAD:  r_state <= ST_MEM_RD;
                        OP_STORE: r_state <= ST_MEM_WR;
                        default:  r_state <= ST_WB;
                    endcase
                end
                ST_MEM_RD: begin
                    if (bus.mem_ready)  r_state <= ST_WB;
                    else if (w_timeout) r_state <= ST_FAULT;
                end
                ST_MEM_WR: begin
                    if (bus.mem_ready)  r_state <= ST_FETCH;
                    else if (w_timeout) r_state <= ST_FAULT;
                end
                ST_WB, ST_BRANCH: r_state <= ST_FETCH;
                default:          r_state <= ST_FAULT;
            endcase
        end
    end

    // Reset masks every strobe immediately so an in-flight request is dropped.
    always_comb begin
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_addr_sel  = 1'b0;
        w_ir_we     = 1'b0;
        w_pc_we     = 1'b0;
        w_pc_src    = 1'b0;
        w_imm_type  = IMM_NONE;
        w_alu_src_b = 1'b0;
        w_alu_op    = ALU_ADD;
        w_reg_we    = 1'b0;
        w_wb_sel    = 1'b0;
        w_fault     = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_FETCH: begin
                    w_mem_req = 1'b1;
                    w_ir_we   = bus.mem_ready;
                    w_pc_we   = bus.mem_ready;
                end
                ST_EXEC: begin
                    case (bus.opcode)
                        OP_RTYPE: w_alu_op = ALU_FUNCT;
                        OP_ITYPE: begin
                            w_imm_type  = IMM_I;
                            w_alu_src_b = 1'b1;
                            w_alu_op    = ALU_FUNCT;
                        end
                        OP_LOAD: begin
                            w_imm_type  = IMM_I;
                            w_alu_src_b = 1'b1;
                        end
                        OP_STORE: begin
                            w_imm_type  = IMM_S;
                            w_alu_src_b = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_MEM_RD: begin
                    w_mem_req  = 1'b1;
                    w_addr_sel = 1'b1;
                end
                ST_MEM_WR: begin
                    w_mem_req  = 1'b1;
                    w_mem_we   = 1'b1;
                    w_addr_sel = 1'b1;
                end
                ST_WB: begin
                    w_reg_we = 1'b1;
                    w_wb_sel = (bus.opcode == OP_LOAD);
                end
                ST_BRANCH: begin
                    w_imm_type = IMM_B;
                    w_alu_op   = ALU_CMP;
                    w_pc_we    = bus.br_taken;
                    w_pc_src   = bus.br_taken;
                end
                ST_FAULT: w_fault = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = w_mem_we;
    assign bus.addr_sel  = w_addr_sel;
    assign bus.ir_we     = w_ir_we;
    assign bus.pc_we     = w_pc_we;
    assign bus.pc_src    = w_pc_src;
    assign bus.imm_type  = w_imm_type;
    assign bus.alu_src_b = w_alu_src_b;
    assign bus.alu_op    = w_alu_op;
    assign bus.reg_we    = w_reg_we;
    assign bus.wb_sel    = w_wb_sel;
    assign bus.fault     = w_fault;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: each instruction is expanded into per-cycle stimulus and
// expected outputs from its type and planned memory waits; a monitor compares.
module tb_multicycle_ctrl;

    localparam int         TMO    = 15;
    localparam logic [6:0] OPC_R  = 7'h33;
    localparam logic [6:0] OPC_I  = 7'h13;
    localparam logic [6:0] OPC_LD = 7'h03;
    localparam logic [6:0] OPC_ST = 7'h23;
    localparam logic [6:0] OPC_BR = 7'h63;

    typedef struct packed {
        logic       mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src;
        logic [1:0] imm_type;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       reg_we, wb_sel, fault;
    } out_t;

    typedef struct packed {
        logic       rst_n;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic       br_taken;
        logic       mem_ready;
    } stim_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    stim_t      p_stim[$];
    out_t       p_exp[$];
    string      p_tag[$];
    out_t       sb_exp[$];
    string      sb_tag[$];
    int         n_vec    = 0;
    int         n_miss   = 0;
    int         n_issued = 0;
    logic [6:0] cur_op   = 7'd0;
    logic [2:0] cur_f3   = 3'd0;

    function automatic out_t idle();
        out_t o;
        o          = '0;
        o.imm_type = 2'd3;
        return o;
    endfunction

    function automatic stim_t mk(input logic rdy);
        stim_t s;
        s.rst_n     = 1'b1;
        s.opcode    = cur_op;
        s.funct3    = cur_f3;
        s.br_taken  = 1'($urandom);
        s.mem_ready = rdy;
        return s;
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        return op == OPC_R || op == OPC_I || op == OPC_LD || op == OPC_ST || op == OPC_BR;
    endfunction

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)  return $urandom_range(0, 3);
        if (r == 7) return TMO - 1;
        if (r == 8) return TMO;
        return $urandom_range(4, TMO - 2);
    endfunction

    task automatic add(input stim_t s, input out_t e, input string tag);
        p_stim.push_back(s);
        p_exp.push_back(e);
        p_tag.push_back(tag);
    endtask

    // A request completes after `waits` idle cycles, or faults after TMO of them.
    task automatic mem_phase(input int waits, input logic we, input logic sel,
                             input logic is_fetch, input string tag, output logic timed_out);
        out_t e;
        int   n;
        n            = (waits < TMO) ? waits : TMO;
        e            = idle();
        e.mem_req    = 1'b1;
        e.mem_we     = we;
        e.addr_sel   = sel;
        for (int i = 0; i < n; i++) add(mk(1'b0), e, tag);
        timed_out = (waits >= TMO);
        if (!timed_out) begin
            e.ir_we = is_fetch;
            e.pc_we = is_fetch;
            add(mk(1'b1), e, tag);
        end
    endtask

    task automatic fault_tail(input int n);
        out_t  e;
        stim_t s;
        e       = idle();
        e.fault = 1'b1;
        for (int i = 0; i < n; i++) add(mk(1'($urandom)), e, "fault_hold");
        s       = mk(1'($urandom));
        s.rst_n = 1'b0;
        add(s, idle(), "fault_reset");
    endtask

    task automatic play();
        for (int i = 0; i < p_stim.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n         = p_stim[i].rst_n;
            bus.opcode    = p_stim[i].opcode;
            bus.funct3    = p_stim[i].funct3;
            bus.br_taken  = p_stim[i].br_taken;
            bus.mem_ready = p_stim[i].mem_ready;
            sb_exp.push_back(p_exp[i]);
            sb_tag.push_back(p_tag[i]);
            n_issued++;
        end
        p_stim.delete();
        p_exp.delete();
        p_tag.delete();
    endtask

    task automatic instr(input string name, input logic [6:0] op, input int fw, input int dw,
                         input logic br, input int abort_at, input int flen);
        stim_t s;
        out_t  e;
        logic  to;
        cur_op = op;
        cur_f3 = 3'($urandom);
        mem_phase(fw, 1'b0, 1'b0, 1'b1, {name, ".fetch"}, to);
        if (to) begin
            fault_tail(flen);
        end else begin
            add(mk(1'($urandom)), idle(), {name, ".decode"});
            if (op == OPC_BR) begin
                s           = mk(1'($urandom));
                s.br_taken  = br;
                e           = idle();
                e.imm_type  = 2'd2;
                e.alu_op    = 2'd1;
                e.pc_we     = br;
                e.pc_src    = br;
                add(s, e, {name, ".branch"});
            end else if (is_legal(op)) begin
                e           = idle();
                e.alu_src_b = (op != OPC_R);
                e.alu_op    = (op == OPC_LD || op == OPC_ST) ? 2'd0 : 2'd2;
                e.imm_type  = (op == OPC_R) ? 2'd3 : (op == OPC_ST) ? 2'd1 : 2'd0;
                add(mk(1'($urandom)), e, {name, ".exec"});
                if (op == OPC_ST) begin
                    mem_phase(dw, 1'b1, 1'b1, 1'b0, {name, ".mem_wr"}, to);
                    if (to) fault_tail(flen);
                end else begin
                    to = 1'b0;
                    if (op == OPC_LD) mem_phase(dw, 1'b0, 1'b1, 1'b0, {name, ".mem_rd"}, to);
                    if (to) begin
                        fault_tail(flen);
                    end else begin
                        e        = idle();
                        e.reg_we = 1'b1;
                        e.wb_sel = (op == OPC_LD);
                        add(mk(1'($urandom)), e, {name, ".wb"});
                    end
                end
            end else begin
                fault_tail(flen);
            end
        end
        if (abort_at > 0 && abort_at < p_exp.size()) begin
            while (p_exp.size() > abort_at) begin
                void'(p_stim.pop_back());
                void'(p_exp.pop_back());
                void'(p_tag.pop_back());
            end
            s       = mk(1'($urandom));
            s.rst_n = 1'b0;
            add(s, idle(), {name, ".abort_reset"});
        end
        $display("instr %s op=%b fetch_wait=%0d data_wait=%0d br=%b abort_at=%0d cycles=%0d",
                 name, op, fw, dw, br, abort_at, p_exp.size());
        play();
    endtask

    out_t  m_exp;
    out_t  m_got;
    string m_tag;

    always @(negedge clk) begin
        if (sb_exp.size() != 0) begin
            m_exp = sb_exp.pop_front();
            m_tag = sb_tag.pop_front();
            m_got = {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_we, bus.pc_we, bus.pc_src,
                     bus.imm_type, bus.alu_src_b, bus.alu_op, bus.reg_we, bus.wb_sel, bus.fault};
            n_vec++;
            if (m_got !== m_exp) begin
                n_miss++;
                $display("FAIL %s: got %b required %b (mreq mwe asel irwe pcwe pcsrc imm2 srcb aluop2 regwe wbsel fault)",
                         m_tag, m_got, m_exp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb_exp.size());
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t      s;
        int         kind;
        int         ab;
        logic [6:0] op;
        rst_n         = 1'b0;
        bus.opcode    = '0;
        bus.funct3    = '0;
        bus.br_taken  = 1'b0;
        bus.mem_ready = 1'b0;

        s       = mk(1'b1);
        s.rst_n = 1'b0;
        add(s, idle(), "por_reset");
        add(s, idle(), "por_reset");
        play();

        instr("addi",       OPC_I,  0,       0,       1'b0, 0, 3);
        instr("lw",         OPC_LD, 1,       3,       1'b0, 0, 3);
        instr("beq_taken",  OPC_BR, 0,       0,       1'b1, 0, 3);
        instr("beq_not",    OPC_BR, 2,       0,       1'b0, 0, 3);
        instr("illegal7f",  7'h7F,  0,       0,       1'b0, 0, 20);
        instr("sw_timeout", OPC_ST, 0,       TMO,     1'b0, 0, 4);
        instr("sw_last",    OPC_ST, 1,       TMO - 1, 1'b0, 0, 3);
        instr("lw_reset",   OPC_LD, 0,       6,       1'b0, 5, 3);
        instr("fetch_tmo",  OPC_R,  TMO,     0,       1'b0, 0, 2);
        instr("fetch_last", OPC_R,  TMO - 1, 0,       1'b0, 0, 2);
        instr("add",        OPC_R,  0,       0,       1'b0, 0, 2);

        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0:       op = OPC_R;
                1:       op = OPC_I;
                2:       op = OPC_LD;
                3:       op = OPC_ST;
                4:       op = OPC_BR;
                default: begin
                    op = 7'($urandom);
                    while (is_legal(op)) op = 7'($urandom);
                end
            endcase
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 8) : 0;
            instr($sformatf("rnd%0d", k), op, pick_wait(), pick_wait(), 1'($urandom), ab,
                  $urandom_range(1, 6));
        end

        repeat (3) @(posedge clk);
        n_vec++;
        if (sb_exp.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb_exp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
